my_adder_pipe: RTL and testbench

MY_ADDER_PIPE -- requirements
Module: my_adder_pipe

---
 rtl/my_adder_pipe.sv | 107 ++++++++++
 tb/tb_my_adder_pipe.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/my_adder_pipe.sv
// Chunked ripple-carry add/subtract pipeline: stage k adds bits [k*CW +: CW] and
// passes its carry, the unconsumed operands and the partial sum down the pipe.
module my_adder_pipe #(
  parameter int WIDTH  = 16,
  parameter int STAGES = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out,
  output logic             cout,
  output logic             ovf,
  output logic             zero
);

  localparam int CW = WIDTH / STAGES;

  logic             r_vld [STAGES];
  logic [WIDTH-1:0] r_a   [STAGES];
  logic [WIDTH-1:0] r_b   [STAGES];
  logic [WIDTH-1:0] r_sum [STAGES];
  logic             r_c   [STAGES];
  logic             r_ovf;
  logic             r_zero;

  logic             w_adv;
  logic             w_vld_in [STAGES];
  logic [WIDTH-1:0] w_a_in   [STAGES];
  logic [WIDTH-1:0] w_b_in   [STAGES];
  logic [WIDTH-1:0] w_sum_in [STAGES];
  logic             w_c_in   [STAGES];
  logic [WIDTH-1:0] w_sum_nx [STAGES];
  logic [CW:0]      w_chunk  [STAGES];
  logic             w_ovf;

  assign w_adv    = out_ready | ~out_valid;
  assign in_ready = w_adv;

  // Stage 0 sees the raw inputs with b inverted and carry forced for subtract.
  always_comb begin
    w_vld_in[0] = in_valid;
    w_a_in[0]   = a;
    w_b_in[0]   = sub ? ~b : b;
    w_sum_in[0] = '0;
    w_c_in[0]   = sub ? 1'b1 : cin;
    for (int k = 1; k < STAGES; k++) begin
      w_vld_in[k] = r_vld[k-1];
      w_a_in[k]   = r_a[k-1];
      w_b_in[k]   = r_b[k-1];
      w_sum_in[k] = r_sum[k-1];
      w_c_in[k]   = r_c[k-1];
    end
    for (int k = 0; k < STAGES; k++) begin
      w_chunk[k] = {1'b0, w_a_in[k][k*CW +: CW]} + {1'b0, w_b_in[k][k*CW +: CW]}
                 + {{CW{1'b0}}, w_c_in[k]};
      w_sum_nx[k] = w_sum_in[k];
      w_sum_nx[k][k*CW +: CW] = w_chunk[k][CW-1:0];
    end
  end

  // Carry into the MSB equals a^b^sum at that bit, so overflow needs no extra adder.
  assign w_ovf = w_a_in[STAGES-1][WIDTH-1] ^ w_b_in[STAGES-1][WIDTH-1]
               ^ w_sum_nx[STAGES-1][WIDTH-1] ^ w_chunk[STAGES-1][CW];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int k = 0; k < STAGES; k++) begin
        r_vld[k] <= 1'b0;
        r_a[k]   <= '0;
        r_b[k]   <= '0;
        r_sum[k] <= '0;
        r_c[k]   <= 1'b0;
      end
      r_ovf  <= 1'b0;
      r_zero <= 1'b1;
    end else if (w_adv) begin
      for (int k = 0; k < STAGES; k++) begin
        r_vld[k] <= w_vld_in[k];
        // Bubbles move the valid bit only, so outputs hold while out_valid is low.
        if (w_vld_in[k]) begin
          r_a[k]   <= w_a_in[k];
          r_b[k]   <= w_b_in[k];
          r_sum[k] <= w_sum_nx[k];
          r_c[k]   <= w_chunk[k][CW];
        end
      end
      if (w_vld_in[STAGES-1]) begin
        r_ovf  <= w_ovf;
        r_zero <= (w_sum_nx[STAGES-1] == '0);
      end
    end
  end

  assign out_valid = r_vld[STAGES-1];
  assign out       = r_sum[STAGES-1];
  assign cout      = r_c[STAGES-1];
  assign ovf       = r_ovf;
  assign zero      = r_zero;

endmodule

// File: tb/tb_my_adder_pipe.sv
// Scoreboard bench for my_adder_pipe: the driver pushes arithmetic-model results,
// an independent monitor pops them whenever an output transfer happens.
module tb_my_adder_pipe;
  localparam int W = 16;
  localparam int S = 4;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         cin = 1'b0;
  logic         sub = 1'b0;
  logic         out_valid;
  logic         out_ready = 1'b1;
  logic [W-1:0] out;
  logic         cout;
  logic         ovf;
  logic         zero;

  my_adder_pipe #(.WIDTH(W), .STAGES(S)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .cin(cin), .sub(sub), .out_valid(out_valid),
    .out_ready(out_ready), .out(out), .cout(cout), .ovf(ovf), .zero(zero)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] out;
    logic         cout;
    logic         ovf;
    logic         zero;
    int           issue;
    bit           chk_lat;
  } exp_t;

  exp_t sbq[$];
  int   cyc = 0;
  int   n_checks = 0;
  int   n_errors = 0;
  bit   rnd_done = 0;

  always @(posedge clk) cyc++;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Plain integer arithmetic: unsigned result for out/cout, signed for overflow.
  function automatic exp_t model(input logic [W-1:0] ta, input logic [W-1:0] tb,
                                 input logic tc, input logic ts);
    exp_t e;
    int ua, ub, sa, sb, ru, rs;
    ua = int'(ta);
    ub = int'(tb);
    sa = int'($signed(ta));
    sb = int'($signed(tb));
    if (ts) begin
      ru = ua - ub;
      rs = sa - sb;
      e.cout = (ua >= ub);
    end else begin
      ru = ua + ub + int'(tc);
      rs = sa + sb + int'(tc);
      e.cout = (ru > 65535);
    end
    e.out = ru[W-1:0];
    e.ovf = (rs > 32767) || (rs < -32768);
    e.zero = (e.out == '0);
    e.issue = 0;
    e.chk_lat = 0;
    return e;
  endfunction

  always @(negedge clk) begin
    exp_t e;
    if (!reset && out_valid && out_ready) begin
      if (sbq.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL unexpected_output: got out=0x%0h with empty scoreboard (t=%0t)", out, $time);
      end else begin
        e = sbq.pop_front();
        check("out", 32'(out), 32'(e.out));
        check("cout", 32'(cout), 32'(e.cout));
        check("ovf", 32'(ovf), 32'(e.ovf));
        check("zero", 32'(zero), 32'(e.zero));
        if (e.chk_lat) check("latency", 32'(cyc - e.issue), 32'(S));
      end
    end
  end

  // Called at posedge+1; returns at posedge+1 after the transfer edge.
  task automatic issue(input logic [W-1:0] ta, input logic [W-1:0] tb,
                       input logic tc, input logic ts, input bit lat);
    int n;
    exp_t e;
    n = 0;
    a = ta; b = tb; cin = tc; sub = ts; in_valid = 1'b1;
    @(negedge clk);
    while (!in_ready && n < 50) begin
      n++;
      @(negedge clk);
    end
    if (!in_ready) begin
      check("issue_timeout_in_ready", 32'(in_ready), 32'd1);
      in_valid = 1'b0;
      return;
    end
    e = model(ta, tb, tc, ts);
    e.issue = cyc;
    e.chk_lat = lat;
    sbq.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    in_valid = 1'b0;
    a = W'($urandom);
    b = W'($urandom);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sbq.size() != 0 && n < 100) begin
      @(posedge clk);
      n++;
    end
    check("drain_empty", 32'(sbq.size()), 32'd0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic [W-1:0] s_out;
    logic         s_cout, s_ovf, s_zero;
    int           n;

    #12;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out", 32'(out), 32'd0);
    check("rst_cout", 32'(cout), 32'd0);
    check("rst_ovf", 32'(ovf), 32'd0);
    check("rst_zero", 32'(zero), 32'd1);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;

    // Directed boundary cases.
    issue(16'hFFFF, 16'h0001, 1'b0, 1'b0, 1);
    issue(16'h7FFF, 16'h0001, 1'b0, 1'b0, 1);
    issue(16'h0005, 16'h0007, 1'b1, 1'b1, 1);
    issue(16'h0FFF, 16'h0001, 1'b0, 1'b0, 1);
    issue(16'h8000, 16'h0001, 1'b0, 1'b1, 1);
    issue(16'h1234, 16'h1234, 1'b1, 1'b1, 1);
    idle();
    drain();

    // Ten back-to-back random operations.
    for (int i = 0; i < 10; i++)
      issue(W'($urandom), W'($urandom), 1'($urandom), 1'($urandom), 1);
    idle();
    drain();

    // Backpressure: three ops, then hold out_ready low for five cycles.
    for (int i = 0; i < 3; i++)
      issue(W'($urandom), W'($urandom), 1'($urandom), 1'($urandom), 0);
    idle();
    out_ready = 1'b0;
    n = 0;
    @(negedge clk);
    while (!out_valid && n < 20) begin
      n++;
      @(negedge clk);
    end
    check("stall_out_valid", 32'(out_valid), 32'd1);
    s_out = out; s_cout = cout; s_ovf = ovf; s_zero = zero;
    in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("stall_in_ready", 32'(in_ready), 32'd0);
      check("stall_valid_hold", 32'(out_valid), 32'd1);
      check("stall_out_hold", 32'(out), 32'(s_out));
      check("stall_flags_hold", {29'd0, cout, ovf, zero}, {29'd0, s_cout, s_ovf, s_zero});
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    out_ready = 1'b1;
    drain();

    // Asynchronous reset with three operations in flight.
    for (int i = 0; i < 3; i++)
      issue(W'($urandom), W'($urandom), 1'($urandom), 1'($urandom), 1);
    idle();
    #2;
    reset = 1'b1;
    sbq.delete();
    #1;
    check("async_rst_out_valid", 32'(out_valid), 32'd0);
    check("async_rst_in_ready", 32'(in_ready), 32'd1);
    check("async_rst_zero", 32'(zero), 32'd1);
    check("async_rst_out", 32'(out), 32'd0);
    @(negedge clk);
    @(posedge clk);
    #2;
    reset = 1'b0;
    @(posedge clk);
    #1;
    issue(16'h00FF, 16'h0F01, 1'b1, 1'b0, 1);
    idle();
    drain();
    repeat (8) @(posedge clk);
    #1;

    // Random traffic with random output backpressure.
    fork
      begin
        for (int i = 0; i < 40; i++) begin
          issue(W'($urandom), W'($urandom), 1'($urandom), 1'($urandom), 0);
          if ($urandom_range(0, 3) == 0) begin
            idle();
            repeat ($urandom_range(1, 3)) @(posedge clk);
            #1;
          end
        end
        idle();
        rnd_done = 1;
      end
      begin
        while (!rnd_done) begin
          @(posedge clk);
          #1;
          out_ready = 1'($urandom_range(0, 1));
        end
      end
    join
    out_ready = 1'b1;
    drain();
    repeat (5) @(posedge clk);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
